prom_boot_loader: RTL and testbench

//  Drives address/enable of the 32x8 boot PROM (5610 part) and reads it out byte by byte.

---
 rtl/prom_boot_pkg.sv | 20 ++
 rtl/prom_byte_packer.sv | 57 +++++
 rtl/prom_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_prom_boot_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prom_boot_pkg.sv
// Shared types and constants for the boot PROM loader: FSM state encoding and PROM geometry.
package prom_boot_pkg;

    localparam int PROM_AW = 5;
    localparam int PROM_DW = 8;

    localparam int DEF_ROM_DEPTH      = 32;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_ACCESS_CYCLES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPTURE,
        PUSH,
        DONE
    } state_e;

endpackage

// File: rtl/prom_byte_packer.sv
// Packs PROM bytes little-endian into one output word and flags when the word is complete.
module prom_byte_packer
    import prom_boot_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            capture,
    input  logic [PROM_DW-1:0]              byte_in,
    output logic [PROM_DW*BYTES_PER_WORD-1:0] word,
    output logic                            word_full
);

    localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [LANE_W-1:0]                 lane_q, lane_d;
    logic [PROM_DW*BYTES_PER_WORD-1:0] word_q, word_d;
    logic                              full_q, full_d;

    // Lanes not yet written in the current word deliberately keep their old contents.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        full_d = full_q;
        if (clear) begin
            lane_d = '0;
            full_d = 1'b0;
        end else if (capture) begin
            word_d[{lane_q, 3'b000} +: PROM_DW] = byte_in;
            if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
                lane_d = '0;
                full_d = 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            full_q <= full_d;
        end
    end

    assign word      = word_q;
    assign word_full = full_q;

endmodule

// File: rtl/prom_boot_loader.sv
// Sequences the 32x8 boot PROM and streams packed words downstream on valid/ready.
// Define PROM_CHECKSUM_EN to add a modulo-256 byte checksum reported on chk_err.
module prom_boot_loader
    import prom_boot_pkg::*;
#(
    parameter int ROM_DEPTH      = DEF_ROM_DEPTH,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int ACCESS_CYCLES  = DEF_ACCESS_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic [PROM_AW-1:0]                prom_a,
    output logic                              prom_ce_n,
    input  logic [PROM_DW-1:0]                prom_d,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [PROM_DW*BYTES_PER_WORD-1:0] word_data,
    output logic [2:0]                        word_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              chk_err
);

    localparam int IDX_W  = PROM_AW + 1;
    localparam int WAIT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [PROM_AW-1:0] prom_a_q, prom_a_d;
    logic               ce_n_q, ce_n_d;
    logic               valid_q, valid_d;
    logic [2:0]         addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pack_clear, pack_capture, word_full;
`ifdef PROM_CHECKSUM_EN
    logic [PROM_DW-1:0] sum_q, sum_d;
    logic               chk_err_q, chk_err_d;
`endif

    // prom_d is sampled on the edge that enters CAPTURE, ACCESS_CYCLES+1 edges after prom_a moved.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        wait_d       = wait_q;
        prom_a_d     = prom_a_q;
        ce_n_d       = ce_n_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pack_clear   = 1'b0;
        pack_capture = 1'b0;
`ifdef PROM_CHECKSUM_EN
        sum_d        = sum_q;
        chk_err_d    = chk_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = ADDR;
                    byte_idx_d = '0;
                    prom_a_d   = '0;
                    ce_n_d     = 1'b0;
                    addr_d     = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pack_clear = 1'b1;
`ifdef PROM_CHECKSUM_EN
                    sum_d      = '0;
                    chk_err_d  = 1'b0;
`endif
                end
            end
            ADDR: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (wait_q == WAIT_W'(ACCESS_CYCLES - 1)) begin
                    state_d      = CAPTURE;
                    pack_capture = 1'b1;
                    byte_idx_d   = byte_idx_q + 1'b1;
`ifdef PROM_CHECKSUM_EN
                    sum_d        = sum_q + prom_d;
`endif
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (word_full) begin
                    state_d = PUSH;
                    ce_n_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    state_d  = ADDR;
                    prom_a_d = byte_idx_q[PROM_AW-1:0];
                end
            end
            PUSH: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + 1'b1;
                    if (byte_idx_q == IDX_W'(ROM_DEPTH)) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
`ifdef PROM_CHECKSUM_EN
                        chk_err_d = (sum_q != 8'h00);
`endif
                    end else begin
                        state_d  = ADDR;
                        prom_a_d = byte_idx_q[PROM_AW-1:0];
                        ce_n_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            wait_q     <= '0;
            prom_a_q   <= '0;
            ce_n_q     <= 1'b1;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PROM_CHECKSUM_EN
            sum_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            prom_a_q   <= prom_a_d;
            ce_n_q     <= ce_n_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PROM_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    prom_byte_packer #(
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pack_clear),
        .capture  (pack_capture),
        .byte_in  (prom_d),
        .word     (word_data),
        .word_full(word_full)
    );

    assign prom_a     = prom_a_q;
    assign prom_ce_n  = ce_n_q;
    assign word_valid = valid_q;
    assign word_addr  = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef PROM_CHECKSUM_EN
    assign chk_err    = chk_err_q;
`else
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_prom_boot_loader.sv
// Scoreboard bench for prom_boot_loader: PROM model with access latency, word monitor, directed loads.
module tb_prom_boot_loader;

    localparam int ACCESS_CYCLES = 2;
    localparam int BUDGET        = 600;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  prom_a;
    logic        prom_ce_n;
    logic [7:0]  prom_d = 8'hEE;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [31:0] word_data;
    logic [2:0]  word_addr;
    logic        busy;
    logic        done;
    logic        chk_err;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rom [0:31];
    int         checks = 0;
    int         fails = 0;
    int         reads = 0;
    int         words_seen = 0;
    int         stable_cnt = 0;
    logic [4:0] last_a = 5'd0;
    logic       last_ce_n = 1'b1;

    prom_boot_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prom_a    (prom_a),
        .prom_ce_n (prom_ce_n),
        .prom_d    (prom_d),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_data (word_data),
        .word_addr (word_addr),
        .busy      (busy),
        .done      (done),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // PROM model: data is only valid once address and enable have been stable ACCESS_CYCLES+1 edges.
    always @(negedge clk) begin
        if (prom_a != last_a || prom_ce_n != last_ce_n) begin
            stable_cnt = 1;
            if (!prom_ce_n) reads++;
        end else begin
            stable_cnt++;
        end
        last_a    = prom_a;
        last_ce_n = prom_ce_n;
        prom_d    = (!prom_ce_n && stable_cnt >= ACCESS_CYCLES + 1) ? rom[prom_a] : 8'hEE;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out after %0d cycles", name, BUDGET);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && word_valid && word_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_word: got addr %0d data 0x%08h, expected no word", word_addr, word_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("word_addr", {29'd0, word_addr}, {29'd0, e.addr});
                checkOutput("word_data", word_data, e.data);
            end
        end
    end

    function automatic logic [31:0] rom_word(input int w);
        return {rom[4*w+3], rom[4*w+2], rom[4*w+1], rom[4*w]};
    endfunction

    function automatic logic exp_chk();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 32; i++) s = s + rom[i];
`ifdef PROM_CHECKSUM_EN
        return (s != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_expected();
        for (int w = 0; w < 8; w++) exp_q.push_back('{addr: 3'(w), data: rom_word(w)});
    endtask

    task automatic applyStimulus();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) report_timeout("wait_done");
    endtask

    task automatic wait_word(input logic [2:0] a);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(word_valid === 1'b1 && word_addr === a) && n < BUDGET);
        if (!(word_valid === 1'b1 && word_addr === a)) report_timeout("wait_word");
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_prom_a"}, {27'd0, prom_a}, 32'd0);
        checkOutput({tag, "_prom_ce_n"}, {31'd0, prom_ce_n}, 32'd1);
        checkOutput({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
        checkOutput({tag, "_word_data"}, word_data, 32'd0);
        checkOutput({tag, "_word_addr"}, {29'd0, word_addr}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_chk_err"}, {31'd0, chk_err}, 32'd0);
    endtask

    task automatic check_load_end(input string tag, input int reads0, input int words0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_ce_n"}, {31'd0, prom_ce_n}, 32'd1);
        checkOutput({tag, "_prom_a_nowrap"}, {27'd0, prom_a}, 32'd31);
        checkOutput({tag, "_reads"}, reads - reads0, 32'd32);
        checkOutput({tag, "_words"}, words_seen - words0, 32'd8);
        checkOutput({tag, "_queue_left"}, exp_q.size(), 32'd0);
        checkOutput({tag, "_chk_err"}, {31'd0, chk_err}, {31'd0, exp_chk()});
    endtask

    initial begin
        int r0;
        int w0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h10 + 8'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 reset = 1'b0;

        $display("[TB] basic load");
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        @(negedge clk);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_done_clr", {31'd0, done}, 32'd0);
        checkOutput("first_prom_a", {27'd0, prom_a}, 32'd0);
        checkOutput("first_ce_n", {31'd0, prom_ce_n}, 32'd0);
        wait_done();
        check_load_end("basic", r0, w0);

        $display("[TB] backpressure at word 2");
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        wait_word(3'd2);
        word_ready = 1'b0;
        begin
            int stall_reads;
            stall_reads = reads;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                checkOutput("stall_valid", {31'd0, word_valid}, 32'd1);
                checkOutput("stall_addr", {29'd0, word_addr}, 32'd2);
                checkOutput("stall_data", word_data, 32'h1B1A1918);
                checkOutput("stall_ce_n", {31'd0, prom_ce_n}, 32'd1);
            end
            checkOutput("stall_no_reads", reads - stall_reads, 32'd0);
        end
        @(posedge clk); #1 word_ready = 1'b1;
        wait_done();
        check_load_end("stall", r0, w0);

        $display("[TB] start while busy and on final handshake");
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        repeat (50) @(posedge clk);
        applyStimulus();
        wait_word(3'd7);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check_load_end("restart_ignored", r0, w0);

        $display("[TB] reset during byte 13");
        push_expected();
        w0 = words_seen;
        applyStimulus();
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!(prom_a === 5'd13 && prom_ce_n === 1'b0) && n < BUDGET);
            if (!(prom_a === 5'd13 && prom_ce_n === 1'b0)) report_timeout("wait_byte13");
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        checkOutput("midreset_words", words_seen - w0, 32'd3);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        @(negedge clk);
        checkOutput("reload_prom_a", {27'd0, prom_a}, 32'd0);
        wait_done();
        check_load_end("reload", r0, w0);

`ifdef PROM_CHECKSUM_EN
        $display("[TB] checksum zero-sum image");
        rom[31] = 8'h3F;
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        wait_done();
        check_load_end("chk_good", r0, w0);
        checkOutput("chk_good_flag", {31'd0, chk_err}, 32'd0);

        $display("[TB] checksum corrupted image");
        rom[0] = 8'h11;
        push_expected();
        r0 = reads; w0 = words_seen;
        applyStimulus();
        wait_done();
        check_load_end("chk_bad", r0, w0);
        checkOutput("chk_bad_flag", {31'd0, chk_err}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
